// File: rtl/max_unpool_stream.sv
// Streaming 2x2 unpooling. Each pooled beat {value, idx} expands into a 2x2
// output window: the top sub-row is emitted as inputs arrive, the bottom
// sub-row is replayed from a one-row line buffer. Max mode places the value
// at its recorded window position (zeros elsewhere); average mode spreads
// value/4 over all four positions.
module max_unpool_stream #(
  parameter int N     = 16,    // data word width, signed fixed point
  parameter int Q     = 12,    // fractional bits, carried through untouched
  parameter int M     = 4,     // pooled map width (>= 2)
  parameter int MH    = 4,     // pooled map height (>= 1)
  parameter bit PTYPE = 1'b1   // 1 = max-unpool, 0 = average-unpool
) (
  input  logic         clk,
  input  logic         global_rst_n,
  input  logic         ce,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_eol,
  output logic         out_eof
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int RW = (MH > 1) ? $clog2(MH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(M - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MH - 1);

  localparam logic [0:0] ST_TOP = 1'b0;
  localparam logic [0:0] ST_BOT = 1'b1;

  // The fixed-point format is only meaningful with at least one integer bit.
  if (Q >= N) begin : g_q_range
    $error("max_unpool_stream: Q must be smaller than N");
  end

  logic [0:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          half_q, half_d;
  logic          vld_q, vld_d;
  logic [N-1:0]  val_q, val_d;
  logic [1:0]    idx_q, idx_d;

  // One pooled row of {idx, value}; contents need no reset because the
  // bottom sub-row only replays entries written during the preceding top pass.
  logic [N+1:0]  line_mem [M];
  logic          wr_en;
  logic [CW-1:0] wr_col;
  logic [CW-1:0] rd_col;
  logic [N+1:0]  rd_word;

  logic          last_col;
  logic          in_fire;
  logic          out_fire;
  logic [1:0]    pos;

  assign last_col = (col_q == COL_LAST);
  // Next column of the walk; wraps at the row end.
  assign rd_col   = last_col ? '0 : col_q + 1'b1;
  // A back-to-back accept lands in the column the walk is about to enter.
  assign wr_col   = vld_q ? col_q + 1'b1 : col_q;
  assign rd_word  = line_mem[rd_col];

  // Accept only on the top pass, and only when the pair register is empty or
  // is handing off its last beat this cycle (never across the row end, which
  // turns into the bottom replay instead).
  assign in_ready = global_rst_n & ce & (state_q == ST_TOP)
                  & (~vld_q | (out_ready & half_q & ~last_col));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = ce & vld_q & out_ready;

  // Walk sequencing: half -> column -> sub-row -> pooled row.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    half_d  = half_q;
    vld_d   = vld_q;
    val_d   = val_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    if (out_fire) begin
      if (!half_q) begin
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
        col_d  = rd_col;
        if (state_q == ST_TOP) begin
          if (last_col) begin
            state_d = ST_BOT;
            vld_d   = 1'b1;
            {idx_d, val_d} = rd_word;
          end else begin
            vld_d = 1'b0;
          end
        end else begin
          if (last_col) begin
            state_d = ST_TOP;
            vld_d   = 1'b0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            vld_d = 1'b1;
            {idx_d, val_d} = rd_word;
          end
        end
      end
    end
    if (in_fire) begin
      val_d = in_data;
      idx_d = in_idx;
      vld_d = 1'b1;
      wr_en = 1'b1;
    end
  end

  // Control and pair registers; ce low leaves every _d equal to its _q.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q <= ST_TOP;
      row_q   <= '0;
      col_q   <= '0;
      half_q  <= 1'b0;
      vld_q   <= 1'b0;
      val_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      half_q  <= half_d;
      vld_q   <= vld_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
    end
  end

  // Line buffer write of each accepted top-pass beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_mem[wr_col] <= {in_idx, in_data};
    end
  end

  assign pos = {state_q == ST_BOT, half_q};

  if (PTYPE) begin : g_max
    // Scatter to the recorded window position, zero elsewhere.
    always_comb begin
      out_data = (pos == idx_q) ? val_q : '0;
    end
  end else begin : g_avg
    // Divide by four, rounding toward minus infinity.
    always_comb begin
      out_data = $signed(val_q) >>> 2;
    end
  end

  assign out_valid = vld_q & ce;
  assign out_eol   = out_valid & half_q & last_col;
  assign out_eof   = out_eol & (state_q == ST_BOT) & (row_q == ROW_LAST);

endmodule

// File: doc/max_unpool_stream.md
# max_unpool_stream

Streaming 2x2 unpooling block: the expanding counterpart of the pooling comparator datapath. Accepts a pooled feature map, one fixed-point value plus 2-bit window index per beat, and emits the full-resolution map in raster order at one value per cycle. Max mode scatters each value to its recorded window position and zero-fills the rest; average mode spreads value/4 to all four positions. Sits after the pooled-result store, feeding the next upsampling/deconvolution stage.

## Interface
- N, 16, data word width (signed two's complement fixed point)
- Q, 12, fractional bits (pass-through; no rescaling beyond the average-mode shift)
- M, 4, pooled map width in values (M >= 2)
- MH, 4, pooled map height in rows (MH >= 1)
- ptype, 1, 1 = max-unpool, 0 = average-unpool
- clk  in  1  single clock, rising edge
- global_rst_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; low freezes all state
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input beat
- in_data  in  N  pooled value
- in_idx  in  2  window position of max: 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right (ignored when ptype=0)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  N  unpooled value
- out_eol  out  1  beat is last of an output row (column 2M-1)
- out_eof  out  1  beat is last of the frame (row 2MH-1, column 2M-1)

## Operation
- Transfer on either side occurs on a rising edge with valid & ready & ce.
- Line buffer: M entries of {value, idx}; no reset required on contents.
- FSM: TOP (upper output row of a pooled row) and BOT (lower output row).
- TOP: each accepted input is registered into the output pair register and written to buffer[col]. Emit two beats: half=0 (column 2col), half=1 (column 2col+1), output sub-row 0.
- After the half=1 beat of col=M-1 transfers: col<=0, state<=BOT.
- BOT: no input accepted (in_ready=0). Replay buffer[0..M-1], two beats each, output sub-row 1. After half=1 of col=M-1: col<=0, row<=row+1 (wrap to 0 after MH-1), state<=TOP.
- Position of a beat: pos = 2*subrow + half.
- ptype=1: out_data = value if pos==idx else 0.
- ptype=0: out_data = value >>> 2 (arithmetic shift, rounds toward minus infinity), all four positions.
- in_ready = ce & state==TOP & (out_valid==0 | (out_ready & half==1 & col!=M-1)); allows back-to-back pairs without bubble.
- out_eol = out_valid & half==1 & col==M-1; out_eof = out_eol & state==BOT & row==MH-1.
- ce low: in_ready=0 and out_valid/out_eol/out_eof forced to 0 combinationally; all registers hold; resumes on the same beat when ce returns.
- Output beat stable (data, flags) while out_valid & !out_ready.

## Timing
- Reset (async assert, sync-safe deassert): state=TOP, row=0, col=0, half=0, out_valid=0, out_data=0, in_ready=0 while global_rst_n low.
- Latency: input accepted at edge k -> first beat valid after edge k; second beat one transfer later.
- Throughput with out_ready=1: 1 output/cycle; TOP accepts one input per 2 cycles; BOT runs 2M cycles with no input.
- Reset mid-frame: all progress dropped; first post-reset input is treated as row 0, col 0, top sub-row.
- Frame wrap: after the eof beat, next accepted input starts a new frame with no idle cycle required.

## Test plan
- ptype=1, M=4, MH=1: inputs 0x1000/idx0, 0x2000/idx1, 0x3000/idx2, 0x4000/idx3, out_ready=1 -> row0: 1000,0,0,2000,0,0,0,0; row1: 0,0,0,0,3000,0,0,4000; eol on beats 8 and 16, eof on beat 16.
- ptype=0: input 0xF000 -> four beats 0xFC00; 0x0003 -> 0x0000; 0xFFFF -> 0xFFFF; 0x4000 -> 0x1000.
- Random out_ready backpressure, random in_valid: out_data/flags stable while stalled, in_ready=0 throughout BOT, output sequence matches golden model.
- MH=2, 8 inputs then 4 more: 32 beats with eof only on beat 32, next beats start row 0 correctly.
- global_rst_n low during BOT beat 3: out_valid=0, out_data=0 immediately; post-reset input 0x1000/idx0 -> beats 1000,0 as top-row col 0.
- ce low 3 cycles mid-pair (after half=0 transferred): in_ready=out_valid=0, no state change; on ce high the half=1 beat appears unchanged.
